// File: rtl/stream_pkg.sv
// -----------------------------------------------------------------------------
// stream_pkg
// Shared width helpers for the streaming width converters.
//   clog2        : ceiling log2 of a positive integer (constant function)
//   out_width    : packed word width for a given chunk width and chunk ratio
//   count_width  : width of a "chunks present" field able to hold 1..ratio
//   idx_width    : width of the chunk index counter (0..ratio-1)
// -----------------------------------------------------------------------------
package stream_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 32'sd0;
    for (int v = value - 32'sd1; v > 32'sd0; v = v / 32'sd2) begin
      result = result + 32'sd1;
    end
    return result;
  endfunction

  function automatic int out_width(input int in_width, input int ratio);
    return in_width * ratio;
  endfunction

  // Needs one extra bit over the index so that the value `ratio` fits.
  function automatic int count_width(input int ratio);
    return clog2(ratio) + 32'sd1;
  endfunction

  function automatic int idx_width(input int ratio);
    return clog2(ratio);
  endfunction

endpackage

// File: rtl/stream_hold_reg.sv
// -----------------------------------------------------------------------------
// stream_hold_reg
// One-entry valid/ready output register. A load replaces the held payload,
// including in the same cycle the old payload drains, so back-to-back words
// flow with no bubble. The caller must only assert `load` when `can_load`.
// Ports:
//   clk, arst     : clock, asynchronous active-high reset
//   load          : capture load_data this cycle
//   load_data     : payload to capture
//   out_ready     : downstream consumes the held payload
//   out_valid     : payload held on out_data
//   out_data      : held payload
//   can_load      : register is empty or draining this cycle
// -----------------------------------------------------------------------------
module stream_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             can_load
);

  logic             valid_q;
  logic             valid_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Next-state: load wins over drain; payload only changes on load.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Valid flag and payload registers.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      valid_q <= 1'b0;
      data_q  <= {WIDTH{1'b0}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign can_load  = !valid_q || out_ready;

endmodule

// File: rtl/nibble_packer.sv
// -----------------------------------------------------------------------------
// nibble_packer
// Streaming width up-converter: packs RATIO chunks of IN_WIDTH bits into one
// OUT_WIDTH word, first chunk at the LSBs. in_last closes a word early; the
// unused upper chunks are zero.
// Ports:
//   clk, arst                      : clock, asynchronous active-high reset
//   in_valid/in_ready/in_data      : chunk input handshake and payload
//   in_last                        : accepted chunk closes the current word
//   out_valid/out_ready/out_data   : packed word output handshake and payload
//   out_count                      : number of valid chunks in out_data
// -----------------------------------------------------------------------------
module nibble_packer
  import stream_pkg::*;
#(
  parameter  int IN_WIDTH  = 4,
  parameter  int RATIO     = 4,
  localparam int OUT_WIDTH = out_width(IN_WIDTH, RATIO),
  localparam int CNT_WIDTH = count_width(RATIO)
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0] out_count
);

  localparam int IDX_WIDTH = idx_width(RATIO);
  localparam int HOLD_WIDTH = CNT_WIDTH + OUT_WIDTH;

  logic [IDX_WIDTH-1:0]  idx_q;
  logic [IDX_WIDTH-1:0]  idx_d;
  logic [OUT_WIDTH-1:0]  acc_q;
  logic [OUT_WIDTH-1:0]  acc_d;

  logic                  accept;
  logic                  complete;
  logic                  idx_at_end;
  logic [OUT_WIDTH-1:0]  merged_word;
  logic [CNT_WIDTH-1:0]  word_count;
  logic [HOLD_WIDTH-1:0] hold_payload;
  logic                  hold_can_load;

  assign in_ready   = hold_can_load;
  assign accept     = in_valid && hold_can_load;
  assign idx_at_end = (idx_q == IDX_WIDTH'(RATIO - 1));
  assign complete   = accept && (idx_at_end || in_last);
  assign word_count = CNT_WIDTH'(idx_q) + CNT_WIDTH'(1);

  // Accumulator with the current chunk merged in at idx; chunks above idx are
  // forced to zero so a partial word is always zero-padded.
  always_comb begin
    merged_word = {OUT_WIDTH{1'b0}};
    for (int i = 0; i < RATIO; i++) begin
      if (IDX_WIDTH'(i) == idx_q) begin
        merged_word[i*IN_WIDTH +: IN_WIDTH] = in_data;
      end else if (IDX_WIDTH'(i) < idx_q) begin
        merged_word[i*IN_WIDTH +: IN_WIDTH] = acc_q[i*IN_WIDTH +: IN_WIDTH];
      end else begin
        merged_word[i*IN_WIDTH +: IN_WIDTH] = {IN_WIDTH{1'b0}};
      end
    end
  end

  // Accumulator and chunk index next-state: clear on completion, advance on accept.
  always_comb begin
    acc_d = acc_q;
    idx_d = idx_q;
    if (complete) begin
      acc_d = {OUT_WIDTH{1'b0}};
      idx_d = {IDX_WIDTH{1'b0}};
    end else if (accept) begin
      acc_d = merged_word;
      idx_d = idx_q + IDX_WIDTH'(1);
    end else begin
      acc_d = acc_q;
      idx_d = idx_q;
    end
  end

  // Accumulator and chunk index registers.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      acc_q <= {OUT_WIDTH{1'b0}};
      idx_q <= {IDX_WIDTH{1'b0}};
    end else begin
      acc_q <= acc_d;
      idx_q <= idx_d;
    end
  end

  assign hold_payload = {word_count, merged_word};

  stream_hold_reg #(
    .WIDTH (HOLD_WIDTH)
  ) u_hold (
    .clk       (clk),
    .arst      (arst),
    .load      (complete),
    .load_data (hold_payload),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  ({out_count, out_data}),
    .can_load  (hold_can_load)
  );

endmodule

// File: tb/tb_nibble_packer.sv
// -----------------------------------------------------------------------------
// tb_nibble_packer
// Self-checking bench for nibble_packer (IN_WIDTH=4, RATIO=4): a vector table,
// hand-written corner sequences and randomized traffic against a queue-based
// reference model.
// -----------------------------------------------------------------------------
module tb_nibble_packer;

  localparam int RATIO = 4;

  logic        clk;
  logic        arst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  out_count;

  nibble_packer dut (
    .clk       (clk),
    .arst      (arst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: chunks of the word in progress plus the held output word.
  logic [3:0]  m_q[$];
  logic        m_valid;
  logic [15:0] m_data;
  logic [2:0]  m_cnt;
  logic        ir_seen;

  typedef struct {
    logic        v;
    logic [3:0]  d;
    logic        l;
    logic        r;
    logic        exp_ir;
    logic        exp_ov;
    logic [15:0] exp_data;
    logic [2:0]  exp_cnt;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_valid = 1'b0;
    m_data  = 16'h0000;
    m_cnt   = 3'd0;
  endtask

  // Assert reset between clock edges and check outputs respond immediately.
  task automatic reset_pulse();
    arst = 1'b1;
    #2;
    model_clear();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_out_count", {29'd0, out_count}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    arst = 1'b0;
  endtask

  // One clock cycle: drive inputs, check in_ready, clock, update model, check outputs.
  task automatic cyc(input logic v, input logic [3:0] d, input logic l, input logic r);
    logic        m_ready;
    logic        done;
    logic [15:0] word;
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = r;
    #1;
    m_ready = !m_valid || r;
    ir_seen = in_ready;
    chk("model_in_ready", {31'd0, in_ready}, {31'd0, m_ready});
    @(posedge clk);
    #1;
    done = 1'b0;
    if (v && m_ready) begin
      m_q.push_back(d);
      if (m_q.size() == RATIO || l) begin
        word = 16'h0000;
        for (int i = 0; i < m_q.size(); i++) begin
          word = word | (16'(m_q[i]) << (4 * i));
        end
        m_data  = word;
        m_cnt   = 3'(m_q.size());
        m_valid = 1'b1;
        m_q.delete();
        done = 1'b1;
      end
    end
    if (!done && m_valid && r) begin
      m_valid = 1'b0;
    end
    chk("model_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("model_out_data", {16'd0, out_data}, {16'd0, m_data});
    chk("model_out_count", {29'd0, out_count}, {29'd0, m_cnt});
  endtask

  initial begin
    arst      = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'h0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    model_clear();
    #1;
    reset_pulse();

    // Full word, early last, cleared accumulator, ignored data while idle.
    vecs[0]  = '{1'b1, 4'h3, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0};
    vecs[1]  = '{1'b1, 4'hC, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0};
    vecs[2]  = '{1'b1, 4'h5, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0};
    vecs[3]  = '{1'b1, 4'hA, 1'b0, 1'b1, 1'b1, 1'b1, 16'hA5C3, 3'd4};
    vecs[4]  = '{1'b1, 4'h7, 1'b0, 1'b1, 1'b1, 1'b0, 16'hA5C3, 3'd4};
    vecs[5]  = '{1'b1, 4'h1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0017, 3'd2};
    vecs[6]  = '{1'b1, 4'h1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0017, 3'd2};
    vecs[7]  = '{1'b1, 4'h2, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0017, 3'd2};
    vecs[8]  = '{1'b1, 4'h3, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0017, 3'd2};
    vecs[9]  = '{1'b1, 4'h4, 1'b0, 1'b1, 1'b1, 1'b1, 16'h4321, 3'd4};
    vecs[10] = '{1'b0, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 16'h4321, 3'd4};
    vecs[11] = '{1'b1, 4'h8, 1'b0, 1'b1, 1'b1, 1'b0, 16'h4321, 3'd4};
    vecs[12] = '{1'b0, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 16'h4321, 3'd4};
    vecs[13] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h4321, 3'd4};
    vecs[14] = '{1'b0, 4'h5, 1'b1, 1'b1, 1'b1, 1'b0, 16'h4321, 3'd4};
    vecs[15] = '{1'b1, 4'h9, 1'b0, 1'b1, 1'b1, 1'b0, 16'h4321, 3'd4};
    vecs[16] = '{1'b1, 4'hA, 1'b0, 1'b1, 1'b1, 1'b0, 16'h4321, 3'd4};
    vecs[17] = '{1'b1, 4'hB, 1'b0, 1'b1, 1'b1, 1'b1, 16'hBA98, 3'd4};

    for (int k = 0; k < 18; k++) begin
      cyc(vecs[k].v, vecs[k].d, vecs[k].l, vecs[k].r);
      chk($sformatf("vec%0d_in_ready", k), {31'd0, ir_seen}, {31'd0, vecs[k].exp_ir});
      chk($sformatf("vec%0d_out_valid", k), {31'd0, out_valid}, {31'd0, vecs[k].exp_ov});
      chk($sformatf("vec%0d_out_data", k), {16'd0, out_data}, {16'd0, vecs[k].exp_data});
      chk($sformatf("vec%0d_out_count", k), {29'd0, out_count}, {29'd0, vecs[k].exp_cnt});
    end

    // Backpressure: held word blocks input, then drains while 0x9 enters as chunk 0.
    reset_pulse();
    cyc(1'b1, 4'h3, 1'b0, 1'b0);
    cyc(1'b1, 4'hC, 1'b0, 1'b0);
    cyc(1'b1, 4'h5, 1'b0, 1'b0);
    cyc(1'b1, 4'hA, 1'b0, 1'b0);
    chk("bp_first_word", {16'd0, out_data}, 32'h0000A5C3);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 4'h9, 1'b1, 1'b0);
      chk("bp_in_ready_low", {31'd0, ir_seen}, 32'd0);
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_data", {16'd0, out_data}, 32'h0000A5C3);
      chk("bp_hold_count", {29'd0, out_count}, 32'd4);
    end
    cyc(1'b1, 4'h9, 1'b1, 1'b1);
    chk("bp_release_ready", {31'd0, ir_seen}, 32'd1);
    chk("bp_chunk0_data", {16'd0, out_data}, 32'h00000009);
    chk("bp_chunk0_count", {29'd0, out_count}, 32'd1);

    // Continuous streaming: words 0x3210 and 0x7654 with in_ready always high.
    reset_pulse();
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, 4'(k), 1'b0, 1'b1);
      chk("stream_in_ready", {31'd0, ir_seen}, 32'd1);
      chk("stream_out_valid", {31'd0, out_valid}, {31'd0, (k == 3 || k == 7)});
      if (k == 3) chk("stream_word0", {16'd0, out_data}, 32'h00003210);
      if (k == 7) chk("stream_word1", {16'd0, out_data}, 32'h00007654);
    end
    // Load-while-drain: single-chunk words replace each other with no bubble.
    for (int k = 1; k < 4; k++) begin
      cyc(1'b1, 4'(k), 1'b1, 1'b1);
      chk("lwd_out_valid", {31'd0, out_valid}, 32'd1);
      chk("lwd_out_data", {16'd0, out_data}, k);
      chk("lwd_out_count", {29'd0, out_count}, 32'd1);
    end

    // Reset mid-word: partial 0xF,0xE discarded, next word starts at chunk 0.
    cyc(1'b1, 4'hF, 1'b0, 1'b1);
    cyc(1'b1, 4'hE, 1'b0, 1'b1);
    reset_pulse();
    cyc(1'b1, 4'h1, 1'b0, 1'b1);
    cyc(1'b1, 4'h2, 1'b0, 1'b1);
    cyc(1'b1, 4'h3, 1'b0, 1'b1);
    cyc(1'b1, 4'h4, 1'b0, 1'b1);
    chk("post_rst_data", {16'd0, out_data}, 32'h00004321);
    chk("post_rst_count", {29'd0, out_count}, 32'd4);
    chk("post_rst_valid", {31'd0, out_valid}, 32'd1);

    // Randomized traffic against the reference model.
    reset_pulse();
    for (int k = 0; k < 3000; k++) begin
      cyc(1'($urandom_range(0, 3) != 0),
          4'($urandom_range(0, 15)),
          1'($urandom_range(0, 4) == 0),
          1'($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
